// File: rtl/connect4_pkg.sv
// Shared definitions for the connect-four win scanner.
// Holds the 2-bit piece encodings, the default slot-sequence geometry and the
// scan controller FSM state type.
package connect4_pkg;

  localparam logic [1:0] PIECE_EMPTY  = 2'b00;
  localparam logic [1:0] PIECE_RED    = 2'b01;
  localparam logic [1:0] PIECE_YELLOW = 2'b10;

  localparam int unsigned SLOTS = 199;
  localparam int unsigned SEQ_W = 2 * SLOTS;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

  // 2'b11 is not a colour and is handled exactly like an empty slot.
  function automatic logic is_colour(logic [1:0] piece);
    return (piece == PIECE_RED) || (piece == PIECE_YELLOW);
  endfunction

endpackage

// File: rtl/piece_run_detector.sv
// Same-colour run tracker for the win scanner.
// Consumes one piece per valid cycle and pulses win (combinationally, for the
// current piece) on the slot where a run first reaches RUN_LEN.
// Ports:
//   clock      - system clock
//   piece      - current 2-bit slot value
//   valid      - piece is a live slot this cycle
//   clear      - synchronous clear of the run state (has priority over valid)
//   win        - current piece completes a winning run
//   win_colour - colour of the winning run (meaningful when win is high)
module piece_run_detector
  import connect4_pkg::*;
#(
  parameter int unsigned RUN_LEN = 4
) (
  input  logic       clock,
  input  logic [1:0] piece,
  input  logic       valid,
  input  logic       clear,
  output logic       win,
  output logic [1:0] win_colour
);

  localparam int unsigned CntW = $clog2(RUN_LEN + 1);
  localparam logic [CntW-1:0] RunMax = CntW'(RUN_LEN);

  logic [CntW-1:0] run_q, run_d;
  logic [1:0]      colour_q, colour_d;

  always_comb begin
    run_d      = run_q;
    colour_d   = colour_q;
    win        = 1'b0;
    win_colour = piece;
    if (clear) begin
      run_d    = '0;
      colour_d = PIECE_EMPTY;
    end else if (valid) begin
      if (!is_colour(piece)) begin
        run_d    = '0;
        colour_d = PIECE_EMPTY;
      end else if (piece == colour_q) begin
        // colour_q is only a colour while run_q >= 1, so this extends a run.
        run_d = (run_q == RunMax) ? run_q : run_q + 1'b1;
      end else begin
        run_d    = CntW'(1);
        colour_d = piece;
      end
      // Saturated runs of the same colour must not re-register.
      win = (run_d == RunMax) && !((piece == colour_q) && (run_q == RunMax));
    end
  end

  always_ff @(posedge clock) begin
    run_q    <= run_d;
    colour_q <= colour_d;
  end

endmodule

// File: rtl/win_scan_controller.sv
// Serial win scanner: captures a slot sequence on start and walks it one slot
// per cycle (slot 0 first), reporting which colours completed a run of
// RUN_LEN and the slot index of the first completed run.
// Ports:
//   clock     - system clock
//   reset     - synchronous active-low reset
//   start     - begin a scan (accepted only in IDLE)
//   combos    - slot sequence, slot 0 in the top two bits
//   busy      - scan in progress
//   done      - one-cycle completion pulse
//   winner    - 00 none, 01 red, 10 yellow, 11 both
//   win_index - slot of the first win, 0 when none
// Optional feature: define WIN_SCAN_EARLY_EXIT_EN to stop the scan on the first
// win instead of always walking every slot.
module win_scan_controller #(
  parameter int unsigned SLOTS   = 199,
  parameter int unsigned RUN_LEN = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [2*SLOTS-1:0] combos,
  output logic               busy,
  output logic               done,
  output logic [1:0]         winner,
  output logic [7:0]         win_index
);

  import connect4_pkg::*;

  localparam int unsigned SeqW = 2 * SLOTS;
  localparam logic [7:0]  SlotsCnt = 8'(SLOTS);

  state_e          state_q, state_d;
  logic [SeqW-1:0] shift_q, shift_d;
  logic [7:0]      slot_q, slot_d;
  logic [1:0]      winner_q, winner_d;
  logic [7:0]      win_index_q, win_index_d;

  logic       start_acc;
  logic       scan_valid;
  logic       det_win;
  logic [1:0] det_colour;

  assign start_acc  = (state_q == StIdle) && start;
  // One extra SCAN cycle after the last slot keeps the fixed SLOTS+1 latency.
  assign scan_valid = (state_q == StScan) && (slot_q < SlotsCnt);

  piece_run_detector #(
    .RUN_LEN (RUN_LEN)
  ) u_detector (
    .clock      (clock),
    .piece      (shift_q[SeqW-1 -: 2]),
    .valid      (scan_valid),
    .clear      (start_acc || !reset),
    .win        (det_win),
    .win_colour (det_colour)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    slot_d      = slot_q;
    winner_d    = winner_q;
    win_index_d = win_index_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          shift_d     = combos;
          slot_d      = '0;
          winner_d    = 2'b00;
          win_index_d = '0;
          state_d     = StScan;
        end
      end
      StScan: begin
        if (scan_valid) begin
          shift_d = shift_q << 2;
          slot_d  = slot_q + 8'd1;
          if (det_win) begin
            winner_d = winner_q | det_colour;
            if (winner_q == 2'b00) win_index_d = slot_q;
`ifdef WIN_SCAN_EARLY_EXIT_EN
            state_d = StDone;
`endif
          end
        end else begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      slot_q      <= '0;
      winner_q    <= 2'b00;
      win_index_q <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      slot_q      <= slot_d;
      winner_q    <= winner_d;
      win_index_q <= win_index_d;
    end
  end

  assign busy      = (state_q == StScan);
  assign done      = (state_q == StDone);
  assign winner    = winner_q;
  assign win_index = win_index_q;

endmodule
